sti_receiver: RTL

//  Serial-to-parallel receiver for the STI serial link (si_data/si_valid, 8/16/24/32-bit frames).

---
 rtl/sti_pkg.sv | 30 +++
 rtl/sti_rx_extract.sv | 51 +++++
 rtl/sti_receiver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sti_pkg.sv
// Shared types and helpers for the STI serial receiver.
//   len_e       : frame length codes as carried on cfg_length
//   state_e     : receiver FSM states
//   frame_bits  : number of serial bits in a frame of the given length code
package sti_pkg;

  typedef enum logic [1:0] {
    LEN_8  = 2'b00,
    LEN_16 = 2'b01,
    LEN_24 = 2'b10,
    LEN_32 = 2'b11
  } len_e;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  function automatic logic [5:0] frame_bits(input len_e len);
    logic [5:0] n;
    case (len)
      LEN_8:   n = 6'd8;
      LEN_16:  n = 6'd16;
      LEN_24:  n = 6'd24;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// Combinational word extraction from an assembled STI frame.
// Ports:
//   frame_i   in  32  assembled frame, bit k of the frame at frame_i[k]
//   len_i     in  len_e frame length code
//   fill_i    in  1   24/32b: 1 = payload in top bits, 0 = payload in bottom bits
//   low_i     in  1   8b: 1 = byte goes to low half of the word, 0 = high half
//   data_o    out 16  reconstructed word
//   pad_nz_o  out 1   at least one pad bit is non-zero
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] frame_i,
  input  len_e        len_i,
  input  logic        fill_i,
  input  logic        low_i,
  output logic [15:0] data_o,
  output logic        pad_nz_o
);

  always_comb begin
    data_o   = 16'h0000;
    pad_nz_o = 1'b0;
    case (len_i)
      LEN_8: begin
        data_o = low_i ? {8'h00, frame_i[7:0]} : {frame_i[7:0], 8'h00};
      end
      LEN_16: begin
        data_o = frame_i[15:0];
      end
      LEN_24: begin
        if (fill_i) begin
          data_o   = frame_i[23:8];
          pad_nz_o = |frame_i[7:0];
        end else begin
          data_o   = frame_i[15:0];
          pad_nz_o = |frame_i[23:16];
        end
      end
      default: begin
        if (fill_i) begin
          data_o   = frame_i[31:16];
          pad_nz_o = |frame_i[15:0];
        end else begin
          data_o   = frame_i[15:0];
          pad_nz_o = |frame_i[31:16];
        end
      end
    endcase
  end

endmodule

// File: rtl/sti_receiver.sv
// STI serial-to-parallel receiver: assembles 8/16/24/32-bit frames from si_data/si_valid,
// extracts the 16-bit word and holds it on a valid/ready output register.
// Ports:
//   clk           in   1      clock, rising edge
//   reset         in   1      synchronous, active-high
//   si_data       in   1      serial data bit
//   si_valid      in   1      bit qualifier, contiguous for a frame
//   cfg_length    in   2      frame length code (len_e)
//   cfg_fill      in   1      24/32b payload placement
//   cfg_msb       in   1      1 = MSB first
//   cfg_low       in   1      8b byte placement
//   po_ready      in   1      consumer ready
//   po_data       out  16     held word
//   po_valid      out  1      held word not yet accepted
//   po_pad_err    out  1      held word had non-zero pad bits
//   po_frame_err  out  1      one-cycle pulse on truncated frame
//   po_overrun    out  1      sticky: word overwritten before acceptance
//   po_frame_cnt  out  CNT_W  completed frame count, wraps
//
// State | meaning
// IDLE  | waiting for first bit; latches config when si_valid rises
// RECV  | collecting bits 1..N-1 of the current frame
module sti_receiver
  import sti_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si_data,
  input  logic             si_valid,
  input  logic [1:0]       cfg_length,
  input  logic             cfg_fill,
  input  logic             cfg_msb,
  input  logic             cfg_low,
  input  logic             po_ready,
  output logic [15:0]      po_data,
  output logic             po_valid,
  output logic             po_pad_err,
  output logic             po_frame_err,
  output logic             po_overrun,
  output logic [CNT_W-1:0] po_frame_cnt
);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        frame_q, frame_d;
  len_e               len_q, len_d;
  logic               fill_q, fill_d;
  logic               msb_q, msb_d;
  logic               low_q, low_d;
  logic               frame_err_q, frame_err_d;
  logic [15:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               pad_q, pad_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   frm_cnt_q, frm_cnt_d;

  logic               complete;
  logic [5:0]         bit_pos;
  logic [15:0]        ext_data;
  logic               ext_pad_nz;

  // Extraction sees frame_d so the last bit counts in the same cycle it arrives.
  sti_rx_extract u_extract (
    .frame_i  (frame_d),
    .len_i    (len_q),
    .fill_i   (fill_q),
    .low_i    (low_q),
    .data_o   (ext_data),
    .pad_nz_o (ext_pad_nz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      len_q       <= LEN_8;
      fill_q      <= 1'b0;
      msb_q       <= 1'b0;
      low_q       <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      pad_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frm_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      msb_q       <= msb_d;
      low_q       <= low_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      pad_q       <= pad_d;
      overrun_q   <= overrun_d;
      frm_cnt_q   <= frm_cnt_d;
    end
  end

  // FSM, bit pointer and frame assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    len_d       = len_q;
    fill_d      = fill_q;
    msb_d       = msb_q;
    low_d       = low_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    bit_pos     = '0;
    case (state_q)
      IDLE: begin
        if (si_valid) begin
          len_d   = len_e'(cfg_length);
          fill_d  = cfg_fill;
          msb_d   = cfg_msb;
          low_d   = cfg_low;
          bit_pos = cfg_msb ? frame_bits(len_e'(cfg_length)) - 6'd1 : 6'd0;
          frame_d = '0;
          frame_d[bit_pos[4:0]] = si_data;
          cnt_d   = 5'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (si_valid) begin
          bit_pos = msb_q ? frame_bits(len_q) - 6'd1 - {1'b0, cnt_q} : {1'b0, cnt_q};
          frame_d[bit_pos[4:0]] = si_data;
          if ({1'b0, cnt_q} == frame_bits(len_q) - 6'd1) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output holding register; a completing word takes priority over the clear on accept.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    pad_d     = pad_q;
    overrun_d = overrun_q;
    frm_cnt_d = frm_cnt_q;
    if (complete) begin
      data_d    = ext_data;
      pad_d     = ext_pad_nz;
      valid_d   = 1'b1;
      frm_cnt_d = frm_cnt_q + CNT_W'(1);
      if (valid_q && !po_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && po_ready) begin
      valid_d = 1'b0;
    end
  end

  assign po_data      = data_q;
  assign po_valid     = valid_q;
  assign po_pad_err   = pad_q;
  assign po_frame_err = frame_err_q;
  assign po_overrun   = overrun_q;
  assign po_frame_cnt = frm_cnt_q;

endmodule
